// File: rtl/flash_pkg.sv
// Shared definitions for the SPI flash operation front-end.
package flash_pkg;

  localparam int unsigned TOL_WD  = 40;
  localparam int unsigned ADDR_WD = 24;
  localparam int unsigned DATA_WD = 8;

  localparam logic [7:0] OPC_WREN = 8'h06;
  localparam logic [7:0] OPC_PP   = 8'h02;
  localparam logic [7:0] OPC_READ = 8'h03;
  localparam logic [7:0] OPC_SE   = 8'h20;
  localparam logic [7:0] OPC_RDID = 8'h9F;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_PROGRAM = 2'd1,
    OP_ERASE   = 2'd2,
    OP_READ_ID = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WREN,
    S_ISSUE,
    S_WAIT_LO,
    S_WAIT_HI,
    S_TIMER,
    S_DONE
  } state_t;

  localparam logic [TOL_WD-1:0] WREN_WORD = {OPC_WREN, {(TOL_WD-8){1'b0}}};

  // Main command word for an operation, laid out as {opcode, addr, data}.
  function automatic logic [TOL_WD-1:0] op_word(input op_t op,
                                                input logic [ADDR_WD-1:0] addr,
                                                input logic [DATA_WD-1:0] data);
    logic [TOL_WD-1:0] w;
    case (op)
      OP_READ:    w = {OPC_READ, addr, {DATA_WD{1'b0}}};
      OP_PROGRAM: w = {OPC_PP, addr, data};
      OP_ERASE:   w = {OPC_SE, addr, {DATA_WD{1'b0}}};
      default:    w = {OPC_RDID, {(TOL_WD-8){1'b0}}};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/flash_wait_timer.sv
// Loadable down-counter that stops at zero and flags it.
module flash_wait_timer #(
  parameter int unsigned WD = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [WD-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [WD-1:0] count;

  assign zero = (count == '0);

  // Load takes priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            count <= '0;
    else if (load)         count <= load_val;
    else if (dec && !zero) count <= count - 1'b1;
  end

endmodule

// File: rtl/flash_op_sequencer.sv
// Expands host flash operations into engine command words, with WREN prefix
// and post-program / post-erase wait timing.
module flash_op_sequencer
  import flash_pkg::*;
#(
  parameter int unsigned T_PP   = 4096,
  parameter int unsigned T_SE   = 65536,
  parameter int unsigned TMR_WD = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_op,
  input  logic [ADDR_WD-1:0] req_addr,
  input  logic [DATA_WD-1:0] req_data,
  input  logic               req_vld,
  output logic               req_rdy,
  output logic [TOL_WD-1:0]  cmd_out,
  output logic               cmd_vld,
  input  logic               cmd_rdy,
  output logic               busy,
  output logic               done
);

  localparam logic [TMR_WD-1:0] PP_LOAD = TMR_WD'(T_PP - 1);
  localparam logic [TMR_WD-1:0] SE_LOAD = TMR_WD'(T_SE - 1);

  state_t             state, state_nxt;
  op_t                op_q;
  logic [ADDR_WD-1:0] addr_q;
  logic [DATA_WD-1:0] data_q;
  logic               wren_q;
  logic               req_fire, cmd_fire;
  logic               cmd_load;
  logic [TOL_WD-1:0]  cmd_nxt;
  logic               tmr_load, tmr_dec, tmr_zero;
  logic [TMR_WD-1:0]  tmr_val;

  // Outputs decode the registered state, so they drop as soon as reset hits.
  assign req_rdy  = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign cmd_vld  = (state == S_WREN) || (state == S_ISSUE);
  assign req_fire = req_vld && req_rdy;
  assign cmd_fire = cmd_vld && cmd_rdy;

  flash_wait_timer #(.WD(TMR_WD)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // State, request latch, WREN flag and the held command word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      cmd_out <= '0;
    end else begin
      state <= state_nxt;
      if (req_fire) begin
        op_q   <= op_t'(req_op);
        addr_q <= req_addr;
        data_q <= req_data;
      end
      if (cmd_fire) wren_q <= (state == S_WREN);
      if (cmd_load) cmd_out <= cmd_nxt;
    end
  end

  // Next state; the command word is loaded on entry to S_WREN/S_ISSUE so it
  // is already stable in the first cycle cmd_vld is high.
  always_comb begin
    state_nxt = state;
    cmd_load  = 1'b0;
    cmd_nxt   = cmd_out;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_dec   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_fire) begin
          cmd_load = 1'b1;
          if (op_t'(req_op) == OP_PROGRAM || op_t'(req_op) == OP_ERASE) begin
            state_nxt = S_WREN;
            cmd_nxt   = WREN_WORD;
          end else begin
            state_nxt = S_ISSUE;
            cmd_nxt   = op_word(op_t'(req_op), req_addr, req_data);
          end
        end
      end
      S_WREN, S_ISSUE: begin
        if (cmd_fire) state_nxt = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!cmd_rdy) state_nxt = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (cmd_rdy) begin
          if (wren_q) begin
            state_nxt = S_ISSUE;
            cmd_load  = 1'b1;
            cmd_nxt   = op_word(op_q, addr_q, data_q);
          end else if (op_q == OP_PROGRAM) begin
            state_nxt = S_TIMER;
            tmr_load  = 1'b1;
            tmr_val   = PP_LOAD;
          end else if (op_q == OP_ERASE) begin
            state_nxt = S_TIMER;
            tmr_load  = 1'b1;
            tmr_val   = SE_LOAD;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_TIMER: begin
        if (tmr_zero) state_nxt = S_DONE;
        else          tmr_dec   = 1'b1;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
